frame_sram_mc: RTL

Multi-channel, byte-lane-addressable framebuffer SRAM: the parametrised successor to the single-channel framebuffer memories. It holds NUM_CH colour planes (default R/G/B) in one block, packing PIX_PER_WORD pixels per word. It provides per-pixel write enables, a handshaked read port with a valid strobe, and a hardware frame-clear engine. It sits between the FIFO-to-SRAM writer and the image-processing/readout pipeline.

---
 rtl/frame_sram_pkg.sv | 43 ++++
 rtl/sram_bank.sv | 51 +++++
 rtl/frame_sram_mc.sv | 123 ++++++++++++
 3 files changed

// File: rtl/frame_sram_pkg.sv
// Shared definitions for the multi-channel framebuffer SRAM.
// Contents:
//   clr_state_t    - clear FSM state encoding
//   CH_R/CH_G/CH_B - colour plane indices
//   replicate_pix  - builds a packed word from one pixel value repeated per lane
//   pixel_index    - linear pixel index of a lane within a word address
package frame_sram_pkg;

  typedef enum logic {
    CLR_IDLE = 1'b0,
    CLR_RUN  = 1'b1
  } clr_state_t;

  localparam int CH_R = 0;
  localparam int CH_G = 1;
  localparam int CH_B = 2;

  // Widest packed word the helper can produce; callers truncate to DATA_W.
  localparam int PACK_MAX_W = 256;

  function automatic logic [PACK_MAX_W-1:0] replicate_pix(
    input logic [31:0] pix,
    input int          pix_w,
    input int          n_lanes
  );
    logic [PACK_MAX_W-1:0] w;
    w = '0;
    for (int i = 0; i < n_lanes; i++) begin
      for (int b = 0; b < pix_w; b++) begin
        if ((i * pix_w + b) < PACK_MAX_W && b < 32) begin
          w[i * pix_w + b] = pix[b];
        end
      end
    end
    return w;
  endfunction

  // Lane 0 holds the lowest pixel index of a word.
  function automatic int pixel_index(input int addr, input int lane, input int pix_per_word);
    return addr * pix_per_word + lane;
  endfunction

endpackage

// File: rtl/sram_bank.sv
// One colour plane of the framebuffer: DEPTH x DATA_W, per-lane write enable,
// synchronous read-first read port. The array itself has no reset; only the
// read output register is reset.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset (read register only)
//   we, be, waddr, wdata - write strobe, lane enables, word address, data
//   re, raddr           - read strobe and word address
//   rdata               - registered read data, holds when re is low
module sram_bank
  import frame_sram_pkg::*;
#(
  parameter int ADDR_W       = 14,
  parameter int PIX_W        = 8,
  parameter int PIX_PER_WORD = 4,
  parameter int DATA_W       = PIX_W * PIX_PER_WORD
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [PIX_PER_WORD-1:0] be,
  input  logic [ADDR_W-1:0]       waddr,
  input  logic [DATA_W-1:0]       wdata,
  input  logic                    re,
  input  logic [ADDR_W-1:0]       raddr,
  output logic [DATA_W-1:0]       rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < PIX_PER_WORD; i++) begin
        if (be[i]) begin
          mem[waddr][i*PIX_W +: PIX_W] <= wdata[i*PIX_W +: PIX_W];
        end
      end
    end
  end

  // Non-blocking update of mem above means a same-edge read sees old data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/frame_sram_mc.sv
// Multi-channel framebuffer SRAM with per-pixel write enables, a 1-cycle
// handshaked read port and a hardware frame-clear engine.
// Ports:
//   clk, rst_n               - clock, asynchronous active-low reset
//   clr_start / clr_busy     - clear request pulse / clear sweep in progress
//   wr_en/wr_ready/wr_addr/wr_ch_mask/wr_be/wr_data - write port
//   rd_req/rd_ready/rd_addr  - read request port
//   rd_valid/rd_data         - one-cycle read strobe and read word (all planes)
module frame_sram_mc
  import frame_sram_pkg::*;
#(
  parameter int                NUM_CH       = 3,
  parameter int                ADDR_W       = 14,
  parameter int                PIX_W        = 8,
  parameter int                PIX_PER_WORD = 4,
  parameter logic [PIX_W-1:0]  CLEAR_VAL    = '0
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     clr_start,
  output logic                                     clr_busy,
  input  logic                                     wr_en,
  output logic                                     wr_ready,
  input  logic [ADDR_W-1:0]                        wr_addr,
  input  logic [NUM_CH-1:0]                        wr_ch_mask,
  input  logic [PIX_PER_WORD-1:0]                  wr_be,
  input  logic [NUM_CH*PIX_W*PIX_PER_WORD-1:0]     wr_data,
  input  logic                                     rd_req,
  output logic                                     rd_ready,
  input  logic [ADDR_W-1:0]                        rd_addr,
  output logic                                     rd_valid,
  output logic [NUM_CH*PIX_W*PIX_PER_WORD-1:0]     rd_data
);

  localparam int DATA_W = PIX_W * PIX_PER_WORD;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [DATA_W-1:0] CLEAR_WORD =
    DATA_W'(replicate_pix(32'(CLEAR_VAL), PIX_W, PIX_PER_WORD));

  clr_state_t        state;
  // One extra bit so the counter never wraps back onto address 0.
  logic [ADDR_W:0]   clr_cnt;

  logic                    wr_acc_p0;
  logic                    rd_acc_p0;
  logic [ADDR_W-1:0]       bank_addr_p0;
  logic [PIX_PER_WORD-1:0] bank_be_p0;

  assign wr_ready  = !clr_busy;
  assign rd_ready  = !clr_busy;
  assign wr_acc_p0 = wr_en  && !clr_busy;
  assign rd_acc_p0 = rd_req && !clr_busy;

  // While the sweep runs it owns the write port of every plane.
  assign bank_addr_p0 = clr_busy ? clr_cnt[ADDR_W-1:0] : wr_addr;
  assign bank_be_p0   = clr_busy ? {PIX_PER_WORD{1'b1}} : wr_be;

  // Clear FSM; clr_start during a sweep is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= CLR_IDLE;
      clr_busy <= 1'b0;
      clr_cnt  <= '0;
    end else begin
      case (state)
        CLR_IDLE: begin
          if (clr_start) begin
            state    <= CLR_RUN;
            clr_busy <= 1'b1;
            clr_cnt  <= '0;
          end
        end
        CLR_RUN: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == LAST_ADDR) begin
            state    <= CLR_IDLE;
            clr_busy <= 1'b0;
          end
        end
        default: begin
          state    <= CLR_IDLE;
          clr_busy <= 1'b0;
        end
      endcase
    end
  end

  // ---- stage p0 -> p1: read acceptance becomes the valid strobe ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc_p0;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_plane
    logic              we_p0;
    logic [DATA_W-1:0] wdata_p0;

    assign we_p0    = clr_busy || (wr_acc_p0 && wr_ch_mask[c]);
    assign wdata_p0 = clr_busy ? CLEAR_WORD : wr_data[c*DATA_W +: DATA_W];

    sram_bank #(
      .ADDR_W       (ADDR_W),
      .PIX_W        (PIX_W),
      .PIX_PER_WORD (PIX_PER_WORD),
      .DATA_W       (DATA_W)
    ) u_bank (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (we_p0),
      .be    (bank_be_p0),
      .waddr (bank_addr_p0),
      .wdata (wdata_p0),
      .re    (rd_acc_p0),
      .raddr (rd_addr),
      .rdata (rd_data[c*DATA_W +: DATA_W])
    );
  end

endmodule
